// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Covers the hex glyph patterns and the pad polarity.
package seg_scan_ctrl_pkg;

    localparam int unsigned SEG_W = 7;

    // Glyphs, active-high, bit 6 = a ... bit 0 = g
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h47;
    localparam logic [SEG_W-1:0] SEG_OFF   = 7'h00;

    // Board pins for anodes and segments are active-low
    localparam bit SEG_ACTIVE_LOW = 1'b1;

    function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] pat);
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to 7-segment glyph, active-high; pad inversion happens at the caller's register.
module seg_hex_decoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] pat_c
);

    always_comb begin
        pat_c = SEG_OFF;
        case (nib)
            4'h0: pat_c = SEG_HEX_0;
            4'h1: pat_c = SEG_HEX_1;
            4'h2: pat_c = SEG_HEX_2;
            4'h3: pat_c = SEG_HEX_3;
            4'h4: pat_c = SEG_HEX_4;
            4'h5: pat_c = SEG_HEX_5;
            4'h6: pat_c = SEG_HEX_6;
            4'h7: pat_c = SEG_HEX_7;
            4'h8: pat_c = SEG_HEX_8;
            4'h9: pat_c = SEG_HEX_9;
            4'hA: pat_c = SEG_HEX_A;
            4'hB: pat_c = SEG_HEX_B;
            4'hC: pat_c = SEG_HEX_C;
            4'hD: pat_c = SEG_HEX_D;
            4'hE: pat_c = SEG_HEX_E;
            4'hF: pat_c = SEG_HEX_F;
            default: pat_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit hex display driver with per-frame input snapshot,
// per-digit enable, decimal points, leading-zero blanking and PWM brightness.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG     = 8,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*NDIG-1:0]     data,
    input  logic [NDIG-1:0]       dp_mask,
    input  logic [NDIG-1:0]       dig_en,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [NDIG-1:0]       an,
    output logic [7:0]            seg,
    output logic                  frame_tk
);

    localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned DATA_W = 4 * NDIG;

    logic [DIV_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   data_snap;
    logic [NDIG-1:0]     dp_snap;
    logic [NDIG-1:0]     en_snap;
    logic                lz_snap;
    logic [BRIGHT_W-1:0] bright_snap;

    logic                capture_c;
    logic                slot_end_c;
    logic                last_c;
    logic [DATA_W-1:0]   data_eff_c;
    logic [NDIG-1:0]     dp_eff_c;
    logic [NDIG-1:0]     en_eff_c;
    logic                lz_eff_c;
    logic [BRIGHT_W-1:0] bright_eff_c;
    logic [BRIGHT_W-1:0] phase_c;
    logic [3:0]          nib_c;
    logic                dp_c;
    logic                en_c;
    logic                lz_c;
    logic [SEG_W-1:0]    pat_c;
    logic [NDIG-1:0]     an_nxt_c;
    logic [7:0]          seg_nxt_c;

    assign capture_c  = (pre == '0) && (idx == '0);
    assign slot_end_c = &pre;
    assign last_c     = (idx == IDX_W'(NDIG - 1));
    assign phase_c    = pre[DIV_W-1 -: BRIGHT_W];

    // Frame-start cycle uses the live inputs so the first slot matches the snapshot being taken
    assign data_eff_c   = capture_c ? data     : data_snap;
    assign dp_eff_c     = capture_c ? dp_mask  : dp_snap;
    assign en_eff_c     = capture_c ? dig_en   : en_snap;
    assign lz_eff_c     = capture_c ? lz_blank : lz_snap;
    assign bright_eff_c = capture_c ? bright   : bright_snap;

    // Digit select plus "this and all higher nibbles are zero" for leading-zero blanking
    always_comb begin
        logic zero_above;
        nib_c      = 4'h0;
        dp_c       = 1'b0;
        en_c       = 1'b0;
        lz_c       = 1'b0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above = zero_above && (data_eff_c[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                nib_c = data_eff_c[4*i +: 4];
                dp_c  = dp_eff_c[i];
                en_c  = en_eff_c[i];
                lz_c  = lz_eff_c && (i != 0) && zero_above;
            end
        end
    end

    seg_hex_decoder u_dec (
        .nib   (nib_c),
        .pat_c (pat_c)
    );

    always_comb begin
        an_nxt_c  = '1;
        seg_nxt_c = {seg_drive(pat_c), ~dp_c};
        if (lz_c) begin
            seg_nxt_c[7:1] = seg_drive(SEG_OFF);
        end
        if (en_c && (phase_c <= bright_eff_c)) begin
            an_nxt_c = ~(NDIG'(1) << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            idx         <= '0;
            data_snap   <= '0;
            dp_snap     <= '0;
            en_snap     <= '0;
            lz_snap     <= 1'b0;
            bright_snap <= '0;
            an          <= '1;
            seg         <= 8'hFF;
            frame_tk    <= 1'b0;
        end else begin
            pre <= pre + DIV_W'(1);
            if (slot_end_c) begin
                idx <= last_c ? '0 : idx + IDX_W'(1);
            end
            if (capture_c) begin
                data_snap   <= data;
                dp_snap     <= dp_mask;
                en_snap     <= dig_en;
                lz_snap     <= lz_blank;
                bright_snap <= bright;
            end
            an       <= an_nxt_c;
            seg      <= seg_nxt_c;
            frame_tk <= slot_end_c && last_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised self-checking bench for seg_scan_ctrl (NDIG=4, DIV_W=4, BRIGHT_W=2)
// against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned NDIG     = 4;
    localparam int unsigned DIV_W    = 4;
    localparam int unsigned BRIGHT_W = 2;
    localparam int unsigned SLOT     = 1 << DIV_W;
    localparam int unsigned FRAME    = NDIG * SLOT;

    logic                clk;
    logic                rst;
    logic [4*NDIG-1:0]   data;
    logic [NDIG-1:0]     dp_mask;
    logic [NDIG-1:0]     dig_en;
    logic                lz_blank;
    logic [BRIGHT_W-1:0] bright;
    logic [NDIG-1:0]     an;
    logic [7:0]          seg;
    logic                frame_tk;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic        m_lz;
    logic [1:0]  m_br;

    seg_scan_ctrl #(
        .NDIG     (NDIG),
        .DIV_W    (DIV_W),
        .BRIGHT_W (BRIGHT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .dp_mask  (dp_mask),
        .dig_en   (dig_en),
        .lz_blank (lz_blank),
        .bright   (bright),
        .an       (an),
        .seg      (seg),
        .frame_tk (frame_tk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    // Segments a..g (a = MSB) lit for each hex glyph
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1111110;  4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;  4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;  4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;  4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;  4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;  4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;  4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;  default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // One clock: predict the registered outputs for cycle n, clock, then compare
    task automatic step(input bit do_rst);
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_tk;
        int         slot;
        int         phase;
        logic [15:0] upper;
        bit         lzb;
        rst = do_rst;
        if (do_rst) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
            e_tk  = 1'b0;
        end else begin
            if (n % FRAME == 0) begin
                m_data = data; m_dp = dp_mask; m_en = dig_en; m_lz = lz_blank; m_br = bright;
            end
            slot  = (n / SLOT) % NDIG;
            phase = (n % SLOT) / (SLOT / 4);
            upper = m_data >> (4 * slot);
            lzb   = m_lz && (slot != 0) && (upper == 16'h0);
            e_an  = (m_en[slot] && phase <= int'(m_br)) ? ~(4'b0001 << slot) : 4'hF;
            e_seg[0]   = ~m_dp[slot];
            e_seg[7:1] = lzb ? 7'h7F : ~glyph(upper[3:0]);
            e_tk  = (n % FRAME == FRAME - 1);
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("frame_tk", 32'(frame_tk), 32'(e_tk));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        n = do_rst ? 0 : n + 1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0);
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while ((n % FRAME) != pos && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        data     = 16'h1234;
        dp_mask  = 4'h0;
        dig_en   = 4'hF;
        lz_blank = 1'b0;
        bright   = 2'd3;

        // Reset held, then normal scan
        for (int i = 0; i < 3; i++) step(1'b1);
        check("first_an", 32'(an), 32'hF);
        run(2 * FRAME);

        // Leading-zero blanking
        data = 16'h0050; lz_blank = 1'b1;
        run(2 * FRAME);
        data = 16'h0000;
        run(2 * FRAME);

        // PWM duty and digit enable
        data = 16'hBEEF; lz_blank = 1'b0; bright = 2'd1; dig_en = 4'b1011;
        run(2 * FRAME);

        // Snapshot coherence across a mid-frame input change
        data = 16'hAAAA; dp_mask = 4'b0001; bright = 2'd3; dig_en = 4'hF;
        run_to(0);
        run_to(2 * SLOT + 3);
        data = 16'h5555;
        run(2 * FRAME);

        // Single-cycle reset in the digit-2 slot
        run_to(2 * SLOT + 5);
        step(1'b1);
        run(FRAME + SLOT);

        // Randomised inputs, changes at arbitrary points, occasional resets
        for (int s = 0; s < 60; s++) begin
            data     = 16'($urandom()) >> (4 * $urandom_range(0, 4));
            dp_mask  = 4'($urandom());
            dig_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            lz_blank = 1'($urandom());
            bright   = 2'($urandom());
            if ($urandom_range(0, 19) == 0) step(1'b1);
            run($urandom_range(1, 90));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
